// File: rtl/cnt_inc_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_inc_arb
//  Purpose  : Round-robin arbiter and rate pacer. Merges N event-request lines
//             into one registered inc strobe for a Gray-coded cross-clock
//             event counter. Bursts are buffered in per-requester pending
//             counters, and successive strobes are spaced by a programmable
//             gap.
//  Config   : CNT_ARB_DROPS_EN - when defined, a saturating lost-event counter
//             drives drops. When undefined, drops is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module cnt_inc_arb #(
    parameter int N  = 4,
    parameter int PW = 4,
    parameter int GW = 4,
    parameter int DW = 8
) (
    input  logic                 clk_a,
    input  logic                 rst_a_n,
    input  logic                 en,
    input  logic [GW-1:0]        gap,
    input  logic [N-1:0]         req,
    input  logic                 clr_ovf,
    output logic                 inc,
    output logic [$clog2(N)-1:0] inc_src,
    output logic                 pending_any,
    output logic [N-1:0]         ovf,
    output logic [DW-1:0]        drops
);

    localparam int              SW    = $clog2(N);
    localparam logic [SW:0]     N_EXT = (SW+1)'(N);
    localparam logic [SW-1:0]   LAST  = SW'(N-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   pend      [N];
    logic [PW-1:0]   pend_next [N];
    logic [N-1:0]    elig;
    logic [N-1:0]    grant_vec;
    logic [N-1:0]    drop_vec;
    logic            any_next;
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   winner;
    logic [SW:0]     rr_sum;
    logic            found;
    logic            decide;
    logic            grant;
    logic [GW-1:0]   gap_cnt;

    // Eligibility is taken from the registered counters only, so an event
    // becomes grantable in the cycle after its request pulse.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = (pend[i] != '0);
        end
    end

    // Round-robin search starting at the pointer, ascending with wrap-around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_sum = '0;
        for (int k = 0; k < N; k++) begin
            rr_sum = {1'b0, rr_ptr} + (SW+1)'(k);
            if (rr_sum >= N_EXT) begin
                rr_sum = rr_sum - N_EXT;
            end
            if (!found && elig[rr_sum[SW-1:0]]) begin
                found  = 1'b1;
                winner = rr_sum[SW-1:0];
            end
        end
    end

    // A grant may only be issued in the cycles where the pacer permits one.
    always_comb begin
        case (state)
            IDLE:    decide = 1'b1;
            ISSUE:   decide = (gap == '0);
            HOLD:    decide = (gap_cnt == GW'(1));
            default: decide = 1'b0;
        endcase
    end

    assign grant = decide & en & found;

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign grant_vec[gi] = grant && (winner == SW'(gi));
        // A lost event is a request that finds its counter full and is not
        // offset by a same-cycle grant.
        assign drop_vec[gi]  = (&pend[gi]) && req[gi] && !grant_vec[gi];
    end

    // Next pending count: +1 per request, -1 per grant, saturating when full.
    always_comb begin
        any_next = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend_next[i] = pend[i];
            if (req[i] && !grant_vec[i] && !(&pend[i])) begin
                pend_next[i] = pend[i] + 1'b1;
            end else if (!req[i] && grant_vec[i]) begin
                pend_next[i] = pend[i] - 1'b1;
            end
            any_next = any_next | (pend_next[i] != '0);
        end
    end

    // Pending counters, registered pending summary and sticky overflow flags.
    // A bit that drops in the same cycle as clr_ovf stays set.
    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            for (int i = 0; i < N; i++) begin
                pend[i] <= '0;
            end
            pending_any <= 1'b0;
            ovf         <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                pend[i] <= pend_next[i];
            end
            pending_any <= any_next;
            ovf         <= (clr_ovf ? '0 : ovf) | drop_vec;
        end
    end

    // Issue FSM. inc follows the grant by one cycle. The gap counter is loaded
    // in ISSUE and counts down in HOLD, and the next decision is made at 1.
    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state   <= IDLE;
            inc     <= 1'b0;
            inc_src <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            inc <= grant;
            if (grant) begin
                inc_src <= winner;
                rr_ptr  <= (winner == LAST) ? '0 : winner + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    gap_cnt <= gap;
                    if (gap == '0) begin
                        state <= grant ? ISSUE : IDLE;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (gap_cnt == GW'(1)) begin
                        state <= grant ? ISSUE : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CNT_ARB_DROPS_EN
    logic [SW:0] drop_cnt;
    logic [DW:0] drop_sum;

    // Several requesters can lose an event in the same cycle, so count them all.
    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < N; i++) begin
            drop_cnt = drop_cnt + (SW+1)'(drop_vec[i]);
        end
        drop_sum = {1'b0, drops} + (DW+1)'(drop_cnt);
    end

    // Saturating lost-event counter, cleared only by reset.
    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            drops <= '0;
        end else begin
            drops <= drop_sum[DW] ? '1 : drop_sum[DW-1:0];
        end
    end
`else
    assign drops = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnt_inc_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnt_inc_arb
//  Purpose  : Self-checking bench for cnt_inc_arb. Directed scenarios and
//             randomized traffic are compared against a behavioural model.
//             The model tracks pending counts, the round-robin pointer, and
//             the earliest cycle in which the next grant may occur.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_inc_arb;

    localparam int N    = 4;
    localparam int PW   = 4;
    localparam int GW   = 4;
    localparam int DW   = 8;
    localparam int SW   = 2;
    localparam int PMAX = (1 << PW) - 1;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk_a   = 1'b0;
    logic          rst_a_n = 1'b0;
    logic          en      = 1'b0;
    logic [GW-1:0] gap     = '0;
    logic [N-1:0]  req     = '0;
    logic          clr_ovf = 1'b0;
    logic          inc;
    logic [SW-1:0] inc_src;
    logic          pending_any;
    logic [N-1:0]  ovf;
    logic [DW-1:0] drops;

    cnt_inc_arb #(.N(N), .PW(PW), .GW(GW), .DW(DW)) dut (
        .clk_a       (clk_a),
        .rst_a_n     (rst_a_n),
        .en          (en),
        .gap         (gap),
        .req         (req),
        .clr_ovf     (clr_ovf),
        .inc         (inc),
        .inc_src     (inc_src),
        .pending_any (pending_any),
        .ovf         (ovf),
        .drops       (drops)
    );

    always #5 clk_a = ~clk_a;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int        mp [N];
    int        mptr;
    int        m_src;
    int        m_drops;
    int        next_ok;
    int        cyc = 0;
    bit        m_inc;
    bit [N-1:0] m_ovf;

    // Observed strobes
    int inc_srcs[$];
    int inc_cycs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_any();
        bit a;
        a = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mp[i] != 0) a = 1'b1;
        end
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mp[i] = 0;
        mptr    = 0;
        m_src   = 0;
        m_drops = 0;
        next_ok = 0;
        m_inc   = 1'b0;
        m_ovf   = '0;
    endtask

    // Advance the model by one cycle. A grant is allowed when enabled, work is
    // pending, and at least gap cycles have elapsed since the last strobe.
    task automatic model_step(input logic [N-1:0] r, input logic e, input logic c);
        int         w;
        int         idx;
        int         nd;
        int         gi;
        bit         g;
        bit [N-1:0] dv;
        g = 1'b0;
        w = 0;
        if (e && cyc >= next_ok) begin
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (!g && mp[idx] > 0) begin
                    g = 1'b1;
                    w = idx;
                end
            end
        end
        m_inc = g;
        if (g) begin
            m_src   = w;
            mptr    = (w + 1) % N;
            next_ok = cyc + 1 + int'(gap);
        end
        dv = '0;
        nd = 0;
        for (int i = 0; i < N; i++) begin
            gi = (g && w == i) ? 1 : 0;
            if (r[i] && gi == 0 && mp[i] == PMAX) begin
                dv[i] = 1'b1;
                nd++;
            end else begin
                mp[i] = mp[i] + int'(r[i]) - gi;
            end
        end
        m_ovf   = (c ? '0 : m_ovf) | dv;
        m_drops = (m_drops + nd > DMAX) ? DMAX : m_drops + nd;
    endtask

    task automatic check_outputs();
        int exp_drops;
`ifdef CNT_ARB_DROPS_EN
        exp_drops = m_drops;
`else
        exp_drops = 0;
`endif
        chk("inc", 32'(inc), 32'(m_inc));
        if (m_inc) chk("inc_src", 32'(inc_src), m_src);
        chk("pending_any", 32'(pending_any), 32'(model_any()));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("drops", 32'(drops), exp_drops);
        if (inc === 1'b1) begin
            inc_srcs.push_back(int'(inc_src));
            inc_cycs.push_back(cyc);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, step the model.
    task automatic cycle(input logic [N-1:0] r, input logic e, input logic c);
        req     = r;
        en      = e;
        clr_ovf = c;
        @(negedge clk_a);
        check_outputs();
        model_step(r, e, c);
        @(posedge clk_a);
        #1;
        cyc++;
    endtask

    // Hold reset for a few cycles with toggling requests. Outputs must be zero
    // immediately after assertion and for as long as reset stays asserted.
    task automatic apply_reset();
        rst_a_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("rst_inc", 32'(inc), 0);
            chk("rst_inc_src", 32'(inc_src), 0);
            chk("rst_pending_any", 32'(pending_any), 0);
            chk("rst_ovf", 32'(ovf), 0);
            chk("rst_drops", 32'(drops), 0);
            req = N'($urandom);
            @(negedge clk_a);
            @(posedge clk_a);
            #1;
        end
        req     = '0;
        rst_a_n = 1'b1;
    endtask

    task automatic clear_capture();
        inc_srcs.delete();
        inc_cycs.delete();
    endtask

    initial begin
        int t0;
        int pr;
        int n;
        logic [N-1:0] r;

        @(posedge clk_a);
        #1;

        // Reset with toggling requests, then 20 quiet cycles without a strobe.
        gap = '0;
        apply_reset();
        clear_capture();
        for (int k = 0; k < 20; k++) cycle('0, 1'b1, 1'b0);
        chk("quiet_after_reset", inc_cycs.size(), 0);

        // Single event on requester 2 at relative cycle 10. Strobe expected at 12.
        apply_reset();
        clear_capture();
        t0 = cyc;
        for (int k = 0; k < 10; k++) cycle('0, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cycle('0, 1'b1, 1'b0);
        chk("single_count", inc_cycs.size(), 1);
        if (inc_cycs.size() > 0) begin
            chk("single_cycle", inc_cycs[0] - t0, 12);
            chk("single_src", inc_srcs[0], 2);
        end
        chk("single_pending_clear", 32'(pending_any), 0);

        // Fairness. All requesters high for 3 cycles give 12 back-to-back strobes.
        apply_reset();
        clear_capture();
        for (int k = 0; k < 3; k++) cycle(4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) cycle('0, 1'b1, 1'b0);
        chk("fair_count", inc_cycs.size(), 12);
        for (int k = 0; k < inc_srcs.size(); k++) begin
            chk("fair_src", inc_srcs[k], k % N);
            if (k > 0) chk("fair_spacing", inc_cycs[k] - inc_cycs[k-1], 1);
        end

        // Pacing. With gap 3, four events give strobes exactly 4 cycles apart.
        gap = 4'd3;
        apply_reset();
        clear_capture();
        for (int k = 0; k < 4; k++) cycle(4'b0001, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) cycle('0, 1'b1, 1'b0);
        chk("pace_count", inc_cycs.size(), 4);
        for (int k = 1; k < inc_cycs.size(); k++) begin
            chk("pace_spacing", inc_cycs[k] - inc_cycs[k-1], 4);
        end

        // Overflow. 17 events into a 15-deep counter lose two.
        gap = '0;
        apply_reset();
        for (int k = 0; k < 17; k++) cycle(4'b0010, 1'b0, 1'b0);
        chk("ovf_bit1", 32'(ovf[1]), 1);
`ifdef CNT_ARB_DROPS_EN
        chk("ovf_drops", 32'(drops), 2);
`else
        chk("ovf_drops", 32'(drops), 0);
`endif
        cycle('0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(ovf), 0);
        clear_capture();
        for (int k = 0; k < 20; k++) cycle('0, 1'b1, 1'b0);
        chk("ovf_drain_count", inc_cycs.size(), 15);

        // Enable gating. The committed strobe issues, and the rest wait for en.
        apply_reset();
        for (int k = 0; k < 5; k++) cycle(4'b0001, 1'b0, 1'b0);
        clear_capture();
        cycle('0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) cycle('0, 1'b0, 1'b0);
        chk("gate_one_issued", inc_cycs.size(), 1);
        for (int k = 0; k < 10; k++) cycle('0, 1'b1, 1'b0);
        chk("gate_total", inc_cycs.size(), 5);

        // Reset asserted while the strobe is high. Pending work is discarded.
        gap = 4'd5;
        apply_reset();
        cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0);
        chk("pre_reset_inc", 32'(inc), 1);
        apply_reset();
        clear_capture();
        for (int k = 0; k < 10; k++) cycle('0, 1'b1, 1'b0);
        chk("post_reset_quiet", inc_cycs.size(), 0);

        // Randomized traffic with several gap settings.
        for (int seg = 0; seg < 6; seg++) begin
            gap = GW'($urandom_range(0, 4));
            pr  = $urandom_range(10, 60);
            for (int k = 0; k < 150; k++) begin
                for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 99) < pr);
                cycle(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 3));
            end
            n = 0;
            while ((model_any() || m_inc) && n < 1000) begin
                cycle('0, 1'b1, 1'b0);
                n++;
            end
            chk("drain_done", 32'(pending_any), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnt_inc_arb.md
# cnt_inc_arb

Round-robin arbiter and rate pacer that merges N independent event-request lines into the single `inc` strobe feeding a Gray-coded cross-clock event counter. It sits entirely in the source (`clk_a`) domain, directly in front of the counter's `inc` input. It buffers bursts in per-requester pending counters and spaces increments by a programmable gap so the slower destination domain never sees more than one count step per sample window.

## Interface
Parameters:
- `N`, 4: number of requesters (≥2)
- `PW`, 4: pending-counter width per requester; depth 2^PW−1 events
- `GW`, 4: gap-field width
- `DW`, 8: drop-counter width (see Configuration)

Ports:
- `clk_a`  in  1  clock; all logic on rising edge
- `rst_a_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  issue enable; pending counters still accumulate when low
- `gap`  in  GW  idle cycles forced after each `inc` (0 = back-to-back allowed)
- `req`  in  N  per-requester event pulse, one event per high cycle
- `clr_ovf`  in  1  clears all `ovf` bits
- `inc`  out  1  registered increment strobe to the counter
- `inc_src`  out  $clog2(N)  requester index served by current `inc`
- `pending_any`  out  1  OR of all non-zero pending counters (registered)
- `ovf`  out  N  sticky: event lost on that requester
- `drops`  out  DW  saturating count of lost events

## Operation
- Reset: `inc`=0, `inc_src`=0, `pending_any`=0, `ovf`=0, `drops`=0; all pending counters 0; RR pointer 0; FSM=IDLE.
- Pending counter p[i]: next = p[i] + req[i] − (grant to i this cycle). If p[i] is saturated, req[i] is high and no grant to i occurs, the event is dropped: `ovf[i]` is set and `drops` increments. Simultaneous req and grant on the same i → p[i] unchanged, no drop.
- Eligible set E = {i : p[i] ≠ 0}; uses registered p, so an event pulsed in cycle t is eligible from cycle t+1.
- Round robin: search E starting at RR pointer, ascending with wrap; winner w. After grant, pointer = (w+1) mod N.
- FSM:
  - IDLE: `inc`=0. If `en` and E≠∅ → grant w; next cycle ISSUE.
  - ISSUE: `inc`=1, `inc_src`=w for exactly one cycle. Load gap counter with `gap`. If `gap`=0, and `en` and E≠∅ (after this decrement) → grant the next winner, stay ISSUE; else IDLE. If `gap`>0 → HOLD.
  - HOLD: `inc`=0; decrement the gap counter; at 1 → IDLE-equivalent decision (grant if `en` and E≠∅, next ISSUE; else IDLE).
- `gap` is sampled only on entry to ISSUE; later changes do not affect an active HOLD.
- `en` deassertion never cancels an `inc` already committed to ISSUE; it blocks the next grant.
- `clr_ovf` has priority over a same-cycle set of `ovf` bits only for bits not dropping that cycle; a bit dropping in the same cycle stays set.
- `drops` saturates at 2^DW−1; it is cleared only by reset.

## Timing
- Latency from an isolated `req[i]` pulse (cycle t, IDLE, `en`=1) to `inc`: `inc` high in cycle t+2 (t+1 grant, t+2 registered strobe).
- Maximum `inc` rate: 1 per (gap+1) cycles.
- Reset asserted mid-HOLD or mid-ISSUE: outputs go to reset values immediately (async); pending events are discarded.
- Wrap: pointer N−1 → 0; with all N requesters pending and `gap`=0, the grant order is 0,1,…,N−1,0,…

## Configuration
- `CNT_ARB_DROPS_EN`: defined → `drops` counter implemented as specified. Undefined → `drops` is tied to 0 and no counter logic is generated; `ovf` behaviour is unchanged.

## Test plan
- Reset: `rst_a_n`=0 with `req` toggling → all outputs 0; after release with `req`=0 → `inc` stays 0 for 20 cycles.
- Single event: `gap`=0, `req[2]` pulse at cycle 10 → `inc`=1, `inc_src`=2 in cycle 12 only; `pending_any` returns to 0.
- Fairness: N=4, `gap`=0, all `req` high for 3 cycles → 12 `inc` pulses, `inc_src` sequence 0,1,2,3 repeated, consecutive cycles.
- Pacing: `gap`=3, `req[0]` held for 4 cycles → `inc` pulses exactly 4 cycles apart, 4 total.
- Overflow: PW=4, `en`=0, `req[1]` high 17 cycles → p[1]=15, `ovf[1]`=1, `drops`=2 (macro defined) or 0 (undefined); `clr_ovf` then clears `ovf`.
- Enable gating: 5 events pending, drop `en` in the cycle a grant is made → that `inc` still issues; no further `inc` until `en` returns, then the remaining 4 issue.
